// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multi-cycle RV32I control FSM.
//   - RV32I major opcode constants and a legality helper
//   - FSM state encoding
//   - ALU control class and trap cause encodings
//   - ctrl_t: the full set of per-state control strobes
package multicycle_control_fsm_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_MATHI  = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_MATHR  = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_RTYPE  = 2'b10,
    ALU_ITYPE  = 2'b11
  } alu_class_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_ILLEGAL  = 2'b01,
    CAUSE_FETCH_TO = 2'b10,
    CAUSE_DATA_TO  = 2'b11
  } trap_cause_e;

  typedef struct packed {
    logic        imem_req;
    logic        dmem_req;
    logic        ir_write;
    logic        pc_write;
    logic        branch;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    alu_class_e  alu_op;
    logic        reg_write;
    logic        retire;
    logic        trap;
    trap_cause_e trap_cause;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_MATHI, OP_AUIPC, OP_STORE, OP_MATHR,
      OP_LUI, OP_BRANCH, OP_JALR, OP_JAL: is_legal_op = 1'b1;
      default:                            is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control/handshake bundle between the control FSM, the memories and the
// datapath.
//   master : the FSM (consumes opcode and ready flags, drives strobes)
//   slave  : datapath/memory side (drives opcode and ready flags)
interface multicycle_control_fsm_if #(
  parameter int ALU_OP_W = 2
);
  logic [6:0]          opcode;
  logic                imem_req;
  logic                imem_ready;
  logic                dmem_req;
  logic                dmem_ready;
  logic                ir_write;
  logic                pc_write;
  logic                branch;
  logic                mem_read;
  logic                mem_write;
  logic                mem_to_reg;
  logic                alu_src;
  logic [ALU_OP_W-1:0] alu_op;
  logic                reg_write;
  logic                retire;
  logic                trap;
  logic [1:0]          trap_cause;

  modport master (
    input  opcode, imem_ready, dmem_ready,
    output imem_req, dmem_req, ir_write, pc_write, branch, mem_read,
           mem_write, mem_to_reg, alu_src, alu_op, reg_write, retire,
           trap, trap_cause
  );

  modport slave (
    output opcode, imem_ready, dmem_ready,
    input  imem_req, dmem_req, ir_write, pc_write, branch, mem_read,
           mem_write, mem_to_reg, alu_src, alu_op, reg_write, retire,
           trap, trap_cause
  );
endinterface

// File: rtl/mcfsm_wait_timer.sv
// Memory-wait watchdog for the control FSM.
//   clk, rst_n : clock, synchronous active-low reset
//   clear_i    : FSM is changing state this cycle; restart the count
//   wait_i     : FSM is waiting on a memory whose ready is low this cycle
//   timeout_o  : this is the WAIT_LIMIT-th consecutive waiting cycle
// WAIT_LIMIT = 0 disables the watchdog (timeout_o stays 0).
module mcfsm_wait_timer #(
  parameter int WAIT_LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic wait_i,
  output logic timeout_o
);
  localparam int CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT    = CW'(WAIT_LIMIT);
  localparam logic [CW-1:0] LIMIT_M1 = CW'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)                        cnt_d = '0;
    else if (wait_i && cnt_q != LIMIT)  cnt_d = cnt_q + 1'b1;  // saturate, never wrap
  end

  // cnt_q holds the waits already completed, so with cnt_q == WAIT_LIMIT-1
  // and ready still low the count reaches WAIT_LIMIT in this cycle.
  assign timeout_o = (WAIT_LIMIT != 0) && wait_i && (cnt_q == LIMIT_M1);

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control FSM: FETCH -> DECODE -> EXEC -> [MEM] -> WB,
// with variable-latency memory handshakes, illegal-opcode and timeout traps.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : multicycle_control_fsm_if.master (opcode, memory
//                handshakes, datapath strobes, trap/trap_cause)
//   cycle_cnt, instret_cnt : performance counters, present only when
//                MCFSM_PERF_CNT_EN is defined
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int ALU_OP_W   = 2,
  parameter int WAIT_LIMIT = 16
`ifdef MCFSM_PERF_CNT_EN
  , parameter int CNT_W    = 32
`endif
) (
  input  logic                          clk,
  input  logic                          rst_n,
  multicycle_control_fsm_if.master      bus
`ifdef MCFSM_PERF_CNT_EN
  , output logic [CNT_W-1:0]            cycle_cnt,
  output logic [CNT_W-1:0]              instret_cnt
`endif
);
  state_e      state_q, state_d;
  logic [6:0]  opcode_q, opcode_d;
  trap_cause_e cause_q, cause_d;
  ctrl_t       ctrl, ctrl_o;
  logic        waiting, timeout;
  logic        is_load, is_store;

  assign is_load  = (opcode_q == OP_LOAD);
  assign is_store = (opcode_q == OP_STORE);
  assign waiting  = ((state_q == ST_FETCH) && !bus.imem_ready) ||
                    ((state_q == ST_MEM)   && !bus.dmem_ready);

  mcfsm_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (state_d != state_q),
    .wait_i    (waiting),
    .timeout_o (timeout)
  );

  // NOTE: every variable written here gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    cause_d  = cause_q;
    ctrl     = '0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        ctrl.imem_req = 1'b1;
        ctrl.ir_write = bus.imem_ready;
        if (bus.imem_ready) begin
          state_d = ST_DECODE;
        end else if (timeout) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_FETCH_TO;
        end
      end
      ST_DECODE: begin
        opcode_d = bus.opcode;
        if (is_legal_op(bus.opcode)) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      ST_EXEC: begin
        case (opcode_q)
          OP_LOAD, OP_STORE: ctrl.alu_src = 1'b1;
          OP_MATHI: begin
            ctrl.alu_op  = ALU_ITYPE;
            ctrl.alu_src = 1'b1;
          end
          OP_MATHR:  ctrl.alu_op = ALU_RTYPE;
          OP_BRANCH: begin
            ctrl.alu_op   = ALU_BRANCH;
            ctrl.branch   = 1'b1;
            ctrl.pc_write = 1'b1;
            ctrl.retire   = 1'b1;
          end
          default: ;
        endcase
        if (opcode_q == OP_BRANCH)     state_d = ST_FETCH;
        else if (is_load || is_store)  state_d = ST_MEM;
        else                           state_d = ST_WB;
      end
      ST_MEM: begin
        ctrl.dmem_req  = 1'b1;
        ctrl.mem_read  = is_load;
        ctrl.mem_write = is_store;
        ctrl.alu_src   = 1'b1;
        if (bus.dmem_ready) begin
          // A store has nothing to write back, so it retires here.
          ctrl.pc_write = is_store;
          ctrl.retire   = is_store;
          state_d       = is_load ? ST_WB : ST_FETCH;
        end else if (timeout) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_DATA_TO;
        end
      end
      ST_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.pc_write   = 1'b1;
        ctrl.retire     = 1'b1;
        ctrl.mem_to_reg = is_load;
        state_d         = ST_FETCH;
      end
      ST_TRAP: begin
        ctrl.trap       = 1'b1;
        ctrl.trap_cause = cause_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are forced low while reset is held, before the first reset edge
  // has had a chance to settle the state register.
  assign ctrl_o = rst_n ? ctrl : '0;

  assign bus.imem_req   = ctrl_o.imem_req;
  assign bus.dmem_req   = ctrl_o.dmem_req;
  assign bus.ir_write   = ctrl_o.ir_write;
  assign bus.pc_write   = ctrl_o.pc_write;
  assign bus.branch     = ctrl_o.branch;
  assign bus.mem_read   = ctrl_o.mem_read;
  assign bus.mem_write  = ctrl_o.mem_write;
  assign bus.mem_to_reg = ctrl_o.mem_to_reg;
  assign bus.alu_src    = ctrl_o.alu_src;
  assign bus.alu_op     = ALU_OP_W'(ctrl_o.alu_op);
  assign bus.reg_write  = ctrl_o.reg_write;
  assign bus.retire     = ctrl_o.retire;
  assign bus.trap       = ctrl_o.trap;
  assign bus.trap_cause = ctrl_o.trap_cause;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      opcode_q <= '0;
      cause_q  <= CAUSE_NONE;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      cause_q  <= cause_d;
    end
  end

`ifdef MCFSM_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, instret_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      if (state_q != ST_IDLE && state_q != ST_TRAP) cycle_cnt_q <= cycle_cnt_q + 1'b1;
      if (ctrl_o.retire)                            instret_cnt_q <= instret_cnt_q + 1'b1;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm (WAIT_LIMIT = 4).
// Each cycle the bench drives inputs, pushes the expected control vector
// into a scoreboard queue and pops/compares it against the DUT outputs.
// Perf-counter checks are built only when MCFSM_PERF_CNT_EN is defined.
module tb_multicycle_control_fsm;
  localparam int WL = 4;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] MATHI  = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] MATHR  = 7'b0110011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;

  typedef struct packed {
    logic       imem_req, dmem_req, ir_write, pc_write, branch;
    logic       mem_read, mem_write, mem_to_reg, alu_src;
    logic [1:0] alu_op;
    logic       reg_write, retire, trap;
    logic [1:0] trap_cause;
  } ctl_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  ctl_t exp_q[$];

  always #5 clk = ~clk;

  multicycle_control_fsm_if #(.ALU_OP_W(2)) bus ();

`ifdef MCFSM_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
  multicycle_control_fsm #(.ALU_OP_W(2), .WAIT_LIMIT(WL), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );
`else
  multicycle_control_fsm #(.ALU_OP_W(2), .WAIT_LIMIT(WL)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master)
  );
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Expected control vectors, built from the behavioural description.
  function automatic ctl_t e_fetch(input logic rdy);
    ctl_t e = '0;
    e.imem_req = 1'b1;
    e.ir_write = rdy;
    return e;
  endfunction

  function automatic ctl_t e_exec(input logic [6:0] op);
    ctl_t e = '0;
    case (op)
      LOAD, STORE: e.alu_src = 1'b1;
      MATHI:       begin e.alu_op = 2'b11; e.alu_src = 1'b1; end
      MATHR:       e.alu_op = 2'b10;
      BRANCH:      begin e.alu_op = 2'b01; e.branch = 1'b1; e.pc_write = 1'b1; e.retire = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic ctl_t e_mem(input logic load, input logic rdy);
    ctl_t e = '0;
    e.dmem_req  = 1'b1;
    e.mem_read  = load;
    e.mem_write = !load;
    e.alu_src   = 1'b1;
    e.pc_write  = !load && rdy;
    e.retire    = !load && rdy;
    return e;
  endfunction

  function automatic ctl_t e_wb(input logic load);
    ctl_t e = '0;
    e.reg_write  = 1'b1;
    e.pc_write   = 1'b1;
    e.retire     = 1'b1;
    e.mem_to_reg = load;
    return e;
  endfunction

  function automatic ctl_t e_trap(input logic [1:0] cause);
    ctl_t e = '0;
    e.trap       = 1'b1;
    e.trap_cause = cause;
    return e;
  endfunction

  // One clock cycle: drive on the falling edge, compare 1 ns later.
  task automatic step(input string tag, input logic rstn, input logic ir,
                      input logic dr, input ctl_t e);
    ctl_t got, want;
    @(negedge clk);
    rst_n          = rstn;
    bus.imem_ready = ir;
    bus.dmem_ready = dr;
    exp_q.push_back(e);
    #1;
    got = {bus.imem_req, bus.dmem_req, bus.ir_write, bus.pc_write, bus.branch,
           bus.mem_read, bus.mem_write, bus.mem_to_reg, bus.alu_src, bus.alu_op,
           bus.reg_write, bus.retire, bus.trap, bus.trap_cause};
    want = exp_q.pop_front();
    check(tag, 32'(got), 32'(want));
  endtask

  // FETCH (after fw not-ready cycles), DECODE, EXEC.
  task automatic fde(input string tag, input logic [6:0] op, input int fw);
    bus.opcode = op;
    for (int i = 0; i < fw; i++) step({tag, ".fetch_wait"}, 1'b1, 1'b0, 1'b0, e_fetch(1'b0));
    step({tag, ".fetch"},  1'b1, 1'b1, 1'b0, e_fetch(1'b1));
    step({tag, ".decode"}, 1'b1, 1'b0, 1'b0, '0);
    step({tag, ".exec"},   1'b1, 1'b0, 1'b0, e_exec(op));
  endtask

  // Complete instruction with fw fetch waits and mw data waits.
  task automatic instr(input string tag, input logic [6:0] op, input int fw, input int mw);
    logic ld;
    ld = (op == LOAD);
    fde(tag, op, fw);
    if (op == LOAD || op == STORE) begin
      for (int i = 0; i < mw; i++) step({tag, ".mem_wait"}, 1'b1, 1'b0, 1'b0, e_mem(ld, 1'b0));
      step({tag, ".mem"}, 1'b1, 1'b0, 1'b1, e_mem(ld, 1'b1));
    end
    if (op != BRANCH && op != STORE) step({tag, ".wb"}, 1'b1, 1'b0, 1'b0, e_wb(ld));
  endtask

  task automatic do_reset(input string tag);
    step({tag, ".rst"},  1'b0, 1'b0, 1'b0, '0);
    step({tag, ".idle"}, 1'b1, 1'b0, 1'b0, '0);
  endtask

  initial begin
    bus.opcode     = MATHR;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;

    step("rst0", 1'b0, 1'b1, 1'b1, '0);
    do_reset("init");

    // Zero-wait R-type twice: retire every 4th cycle.
    instr("mathr0", MATHR, 0, 0);
    instr("mathr1", MATHR, 0, 0);
    // Load with 3 wait cycles; ready on the 4th MEM cycle beats the watchdog.
    instr("load_w3", LOAD, 0, 3);
    instr("branch", BRANCH, 0, 0);
    // Fetch ready on the 4th FETCH cycle: no trap.
    instr("mathi_fw3", MATHI, 3, 0);
    instr("store", STORE, 0, 0);
    instr("lui", LUI, 0, 0);
    instr("jal", JAL, 0, 0);

    // Reset in the middle of a store's MEM phase.
    fde("store_rst", STORE, 0);
    step("store_rst.mem_wait", 1'b1, 1'b0, 1'b0, e_mem(1'b0, 1'b0));
    step("store_rst.rst",      1'b0, 1'b0, 1'b1, '0);
    step("store_rst.idle",     1'b1, 1'b0, 1'b1, '0);

    // Fetch timeout: 4 not-ready FETCH cycles then TRAP cause 10.
    for (int i = 0; i < WL; i++) step("fetch_to.wait", 1'b1, 1'b0, 1'b0, e_fetch(1'b0));
    for (int i = 0; i < 3; i++)  step("fetch_to.trap", 1'b1, 1'b1, 1'b1, e_trap(2'b10));
    do_reset("fetch_to");

    // Data timeout on a load.
    fde("data_to", LOAD, 0);
    for (int i = 0; i < WL; i++) step("data_to.wait", 1'b1, 1'b0, 1'b0, e_mem(1'b1, 1'b0));
    for (int i = 0; i < 2; i++)  step("data_to.trap", 1'b1, 1'b0, 1'b1, e_trap(2'b11));
    do_reset("data_to");

    // Illegal opcode: TRAP cause 01, held for 20 cycles, reset clears it.
    bus.opcode = 7'b0000000;
    step("illegal.fetch",  1'b1, 1'b1, 1'b0, e_fetch(1'b1));
    step("illegal.decode", 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 20; i++)
      step("illegal.trap", 1'b1, 1'(i % 2), 1'(i % 3 == 0), e_trap(2'b01));
    do_reset("illegal");
    instr("after_trap", MATHR, 0, 0);

`ifdef MCFSM_PERF_CNT_EN
    do_reset("perf");
    check("perf.cycle0",   cycle_cnt,   32'd0);
    check("perf.instret0", instret_cnt, 32'd0);
    for (int i = 0; i < 5; i++) instr("perf.mathi", MATHI, 0, 0);
    @(negedge clk);
    #1;
    check("perf.cycle20",  cycle_cnt,   32'd20);
    check("perf.instret5", instret_cnt, 32'd5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
